i2c_init_seq: RTL and testbench
===============================

Name: i2c_init_seq

Overview:
- Table-driven configuration sequencer sitting directly upstream of the I2C byte controller (i2c_ctrl).
- Walks a command table in external ROM/register file and issues register writes, read-verify transactions and timed delays.
- Retries a failed transaction a bounded number of times and reports completion or a failure with the offending table index.
- Also generates the controller's i2c_strobe bit-phase tick.

Parameters:
- CLK_DIV, 4, clk cycles per i2c_strobe pulse; must be >= 2.
- IDX_W, 6, table index width; table depth = 2**IDX_W.
- MAX_RETRY, 3, retries after the first attempt before declaring failure.
- DLY_W, 16, delay unit counter width; one delay unit = 2**DLY_W clk cycles.

Ports:
- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a run from index 0; ignored while busy
- busy  out  1  run in progress
- done  out  1  single-cycle pulse at end of a successful run
- error  out  1  sticky; set on retry exhaustion, cleared by next accepted start
- err_index  out  IDX_W  table index of the failed entry; valid while error=1
- rom_addr  out  IDX_W  table read address
- rom_data  in  18  table word, valid 1 clk after rom_addr: [17:16] op, [15:8] reg addr, [7:0] data
- i2c_strobe  out  1  bit-phase tick to controller
- i2c_enable  out  1  transaction request to controller
- reg_rdwr  out  1  0 = write, 1 = read
- reg_addr  out  8  register address
- reg_len  out  5  byte count incl. device-address byte
- reg_wrdata  out  8  write data
- reg_rddata  in  8  read data from controller
- reg_done  in  1  controller end-of-transaction, high for one strobe period
- i2c_ack  in  1  last sampled acknowledge bit; 1 = NACK

Behaviour:
- Reset: all outputs 0; rom_addr 0; state IDLE; strobe counter 0.
- Strobe generator:
  - Free-running counter 0..CLK_DIV-1; i2c_strobe=1 for one cycle when the counter equals CLK_DIV-1.
  - Runs independently of state.
- Ops:
  - 00 WRITE: reg_rdwr=0, reg_len=3.
  - 01 READ-VERIFY: reg_rdwr=1, reg_len=2; compare reg_rddata to data.
  - 10 DELAY: wait data*2**DLY_W clk cycles; data=0 means no wait.
  - 11 END: finish run.
- States:
  - IDLE: on start → busy=1, error=0, idx=0, retry=0, go to FETCH.
  - FETCH: drive rom_addr=idx, wait one cycle, latch rom_data, go to DECODE.
  - DECODE: branch by op.
    - WRITE/READ: load reg_* outputs, go to ISSUE.
    - DELAY: load delay counter, go to DELAY.
    - END: go to FINISH.
  - ISSUE: assert i2c_enable; hold reg_* stable; go to WAIT.
  - WAIT:
    - Detect the reg_done rising edge using a registered copy of reg_done.
    - On the edge, drop i2c_enable in the same cycle the edge is seen, then go to CHECK.
    - This works because the controller samples enable only on strobe and CLK_DIV >= 2.
  - CHECK:
    - WRITE fails if i2c_ack=1; READ fails if reg_rddata != data (i2c_ack ignored for reads).
    - On pass: retry=0, go to NEXT.
    - On fail with retry < MAX_RETRY: retry+1, wait for reg_done low, then ISSUE.
    - Otherwise go to FAIL.
  - DELAY: count down to 0, then NEXT.
  - NEXT: if idx == 2**IDX_W-1, go to FINISH (table end without END op); else idx+1, go to FETCH.
  - FINISH: done pulse, busy=0, go to IDLE.
  - FAIL: error=1, err_index=idx, busy=0, i2c_enable=0, go to IDLE; no done pulse.
- Handshakes and stability:
  - i2c_enable never rises while reg_done=1.
  - reg_* outputs are constant from ISSUE until CHECK.
- Reset mid-operation: everything returns to reset values immediately. The controller is reset on the same arst_n; no bus recovery is performed here.
- start while busy: ignored, no effect on the run.

Test Plan:
- CLK_DIV=4 after reset → i2c_strobe high exactly every 4th clk, first pulse at cycle 4.
- Table {WRITE 0x10/0xA5, END}, model always ACKs → one transaction with reg_len=3, reg_addr=0x10, reg_wrdata=0xA5; done pulse; error=0; i2c_enable asserted once.
- Table {WRITE 0x20/0x01}, model NACKs (i2c_ack=1) every time, MAX_RETRY=3 → exactly 4 transactions, then error=1, err_index=0, busy=0, no done.
- Table {READ 0x30/0x5A, END}, model returns 0x00 then 0x5A → 2 transactions, done, error=0.
- Table {DELAY 2, WRITE 0x01/0x02, END}, DLY_W=4 → first i2c_enable at least 32 clk after DELAY decode.
- Table with no END (all WRITE) and IDX_W=2 → exactly 4 transactions, then done; start pulse during the run ignored; arst_n low mid-WAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/i2c_init_seq_if.sv
// Sequencer-to-byte-controller bus: strobe, request, register command and result.
// The sequencer drives the command side; the controller returns data, done and ACK.
interface i2c_init_seq_if;
    logic       i2c_strobe;
    logic       i2c_enable;
    logic       reg_rdwr;
    logic [7:0] reg_addr;
    logic [4:0] reg_len;
    logic [7:0] reg_wrdata;
    logic [7:0] reg_rddata;
    logic       reg_done;
    logic       i2c_ack;

    modport master (
        output i2c_strobe, i2c_enable, reg_rdwr, reg_addr, reg_len, reg_wrdata,
        input  reg_rddata, reg_done, i2c_ack
    );

    modport slave (
        input  i2c_strobe, i2c_enable, reg_rdwr, reg_addr, reg_len, reg_wrdata,
        output reg_rddata, reg_done, i2c_ack
    );
endinterface

// File: rtl/i2c_init_seq.sv
// Table-driven I2C init sequencer: fetch (2 clk), decode, issue, wait for reg_done, verify, retry.
// Stalls on the controller's reg_done handshake and on delay entries; start ignored while busy.
module i2c_init_seq #(
    parameter int CLK_DIV   = 4,
    parameter int IDX_W     = 6,
    parameter int MAX_RETRY = 3,
    parameter int DLY_W     = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_index,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [17:0]      rom_data,
    i2c_init_seq_if.master   ctl
);
    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_DLY = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_ISSUE, S_WAIT,
        S_CHECK, S_DELAY, S_NEXT, S_FINISH, S_FAIL
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   div_cnt;
    logic [IDX_W-1:0]   idx;
    logic [RTY_W-1:0]   retry;
    logic [17:0]        cmd;
    logic [DLY_W+7:0]   dly_cnt;
    logic               reg_done_q;
    logic               rdwr_q;
    logic [7:0]         addr_q;
    logic [4:0]         len_q;
    logic [7:0]         wrdata_q;
    logic               enable;
    logic [1:0]         op;
    logic [7:0]         data;
    logic               done_rise;
    logic               check_pass;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                        div_cnt <= div_cnt + 1'b1;
    end

    assign op         = cmd[17:16];
    assign data       = cmd[7:0];
    assign done_rise  = ctl.reg_done & ~reg_done_q;
    // Reads are judged on data alone; the ACK of the last read byte is meaningless.
    assign check_pass = (op == OP_RD) ? (ctl.reg_rddata == data) : ~ctl.i2c_ack;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        enable   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_FETCH;
            end
            S_FETCH:  state_nx = S_LATCH;
            S_LATCH:  state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_WR, OP_RD: state_nx = S_ISSUE;
                    OP_DLY:       state_nx = S_DELAY;
                    default:      state_nx = S_FINISH;
                endcase
            end
            // Hold off the request until the previous transaction's done has cleared.
            S_ISSUE: begin
                if (!ctl.reg_done) begin
                    enable   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_rise) state_nx = S_CHECK;
                else           enable   = 1'b1;
            end
            S_CHECK: begin
                if (check_pass)             state_nx = S_NEXT;
                else if (retry < RTY_MAX)   state_nx = S_ISSUE;
                else                        state_nx = S_FAIL;
            end
            S_DELAY: if (dly_cnt == '0) state_nx = S_NEXT;
            S_NEXT:  state_nx = (idx == IDX_LAST) ? S_FINISH : S_FETCH;
            S_FINISH: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_FAIL: begin
                busy     = 1'b0;
                state_nx = S_IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            idx        <= '0;
            retry      <= '0;
            cmd        <= '0;
            dly_cnt    <= '0;
            reg_done_q <= 1'b0;
            error      <= 1'b0;
            err_index  <= '0;
            rdwr_q     <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wrdata_q   <= '0;
        end else begin
            reg_done_q <= ctl.reg_done;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        retry <= '0;
                        error <= 1'b0;
                    end
                end
                S_LATCH: cmd <= rom_data;
                S_DECODE: begin
                    if (op == OP_DLY) dly_cnt <= {data, {DLY_W{1'b0}}};
                    if (op == OP_WR || op == OP_RD) begin
                        rdwr_q   <= (op == OP_RD);
                        len_q    <= (op == OP_RD) ? 5'd2 : 5'd3;
                        addr_q   <= cmd[15:8];
                        wrdata_q <= data;
                    end
                end
                S_CHECK: begin
                    if (check_pass) begin
                        retry <= '0;
                    end else if (retry < RTY_MAX) begin
                        retry <= retry + 1'b1;
                    end else begin
                        error     <= 1'b1;
                        err_index <= idx;
                    end
                end
                S_DELAY: if (dly_cnt != '0) dly_cnt <= dly_cnt - 1'b1;
                S_NEXT:  if (idx != IDX_LAST) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign rom_addr       = idx;
    assign ctl.i2c_strobe = (div_cnt == DIV_LAST);
    assign ctl.i2c_enable = enable;
    assign ctl.reg_rdwr   = rdwr_q;
    assign ctl.reg_addr   = addr_q;
    assign ctl.reg_len    = len_q;
    assign ctl.reg_wrdata = wrdata_q;
endmodule

// File: tb/tb_i2c_init_seq.sv
// Bench for i2c_init_seq: ROM and byte-controller models, scoreboard of expected transactions.
`timescale 1ns/1ps
module tb_i2c_init_seq;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic        busy, done, error;
    logic [1:0]  err_index, rom_addr;
    logic [17:0] rom_data;

    i2c_init_seq_if ifc();

    i2c_init_seq #(.CLK_DIV(4), .IDX_W(2), .MAX_RETRY(3), .DLY_W(4)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .busy(busy), .done(done),
        .error(error), .err_index(err_index), .rom_addr(rom_addr),
        .rom_data(rom_data), .ctl(ifc)
    );

    typedef struct packed {
        logic       rdwr;
        logic [4:0] len;
        logic [7:0] addr;
        logic [7:0] wrdata;
    } txn_t;
    typedef struct packed {
        logic       ack;
        logic [7:0] rd;
    } resp_t;

    txn_t        exp_q[$];
    resp_t       resp_q[$];
    logic [17:0] rom [4];
    logic [1:0]  rom_addr_q;
    int          checks = 0, failures = 0;
    int          cyc = 0, n_txn = 0, n_en_rise = 0, en_cyc = -1;
    logic        m_active = 1'b0, prev_en = 1'b0;
    int          m_cnt = 0;
    txn_t        m_exp;
    resp_t       m_resp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ent(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        return {op, a, d};
    endfunction

    task automatic push_txn(input logic rdwr, input logic [4:0] len, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.rdwr = rdwr; t.len = len; t.addr = a; t.wrdata = d;
        exp_q.push_back(t);
    endtask

    task automatic push_resp(input logic ack, input logic [7:0] rd);
        resp_t r;
        r.ack = ack; r.rd = rd;
        resp_q.push_back(r);
    endtask

    task automatic cmp_txn(input string pfx);
        chk({pfx, "_rdwr"}, 32'(ifc.reg_rdwr), 32'(m_exp.rdwr));
        chk({pfx, "_len"},  32'(ifc.reg_len),  32'(m_exp.len));
        chk({pfx, "_addr"}, 32'(ifc.reg_addr), 32'(m_exp.addr));
        if (!m_exp.rdwr) chk({pfx, "_wrdata"}, 32'(ifc.reg_wrdata), 32'(m_exp.wrdata));
    endtask

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    // Synchronous ROM with one clock of read latency.
    initial begin
        rom_data = '0;
        rom_addr_q = '0;
        forever begin
            @(negedge clk);
            rom_data   = rom[rom_addr_q];
            rom_addr_q = rom_addr;
        end
    end

    // Byte-controller model: accepts enable on a strobe, raises reg_done on the 3rd strobe after.
    initial begin
        ifc.reg_done = 1'b0; ifc.i2c_ack = 1'b0; ifc.reg_rddata = '0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                m_active = 1'b0; m_cnt = 0; prev_en = 1'b0; ifc.reg_done = 1'b0;
            end else begin
                if (ifc.i2c_enable && !prev_en) begin
                    n_en_rise++;
                    if (en_cyc < 0) en_cyc = cyc;
                    chk("enable_rise_while_done", 32'(ifc.reg_done), 0);
                end
                prev_en = ifc.i2c_enable;
                if (ifc.i2c_strobe) begin
                    if (!m_active) begin
                        if (ifc.i2c_enable) begin
                            m_active = 1'b1; m_cnt = 0; n_txn++;
                            chk("txn_expected", 32'(exp_q.size() > 0), 1);
                            if (exp_q.size() > 0) begin
                                m_exp = exp_q.pop_front();
                                cmp_txn("txn_start");
                            end
                            if (resp_q.size() > 0) m_resp = resp_q.pop_front();
                            else                   m_resp = '0;
                        end
                    end else begin
                        m_cnt++;
                        if (m_cnt == 3) begin
                            ifc.reg_done = 1'b1; ifc.i2c_ack = m_resp.ack; ifc.reg_rddata = m_resp.rd;
                            cmp_txn("txn_hold");
                        end else if (m_cnt == 4) begin
                            ifc.reg_done = 1'b0; m_active = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic set_rom(input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2, input logic [17:0] e3);
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
        n_txn = 0; n_en_rise = 0; en_cyc = -1;
    endtask

    // Pulse start, then follow the run until busy drops; poke re-pulses start mid-run.
    task automatic run_seq(input int poke, output int n_done, output int s_cyc);
        bit fin;
        n_done = 0; fin = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; s_cyc = cyc;
        for (int i = 0; i < 3000; i++) begin
            start = (i == poke);
            if (done) n_done++;
            if (!busy) begin fin = 1; break; end
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_completes", 32'(fin), 1);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, sc, gap;
        bit hit;
        arst_n = 1'b0; start = 1'b0;
        set_rom(ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00));
        @(negedge clk);
        chk("rst_ctl", 32'({busy, done, error, err_index, rom_addr}), 0);
        chk("rst_bus", 32'({ifc.i2c_strobe, ifc.i2c_enable, ifc.reg_rdwr, ifc.reg_addr, ifc.reg_len, ifc.reg_wrdata}), 0);
        @(negedge clk); arst_n = 1'b1;

        // Cycle 1 is the interval before the first edge, so the 4th cycle begins at edge 3.
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("strobe_edge%0d", k), 32'(ifc.i2c_strobe), 32'((k % 4) == 3));
        end

        // Single write then END.
        set_rom(ent(2'd0, 8'h10, 8'hA5), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00));
        push_txn(1'b0, 5'd3, 8'h10, 8'hA5); push_resp(1'b0, 8'h00);
        run_seq(-1, nd, sc);
        chk("wr_txns", n_txn, 1);
        chk("wr_enable_rises", n_en_rise, 1);
        chk("wr_done", nd, 1);
        chk("wr_error", 32'(error), 0);
        chk("wr_sb_empty", exp_q.size(), 0);

        // Persistent NACK exhausts retries.
        set_rom(ent(2'd0, 8'h20, 8'h01), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00));
        for (int i = 0; i < 4; i++) begin push_txn(1'b0, 5'd3, 8'h20, 8'h01); push_resp(1'b1, 8'h00); end
        run_seq(-1, nd, sc);
        chk("nack_txns", n_txn, 4);
        chk("nack_done", nd, 0);
        chk("nack_error", 32'(error), 1);
        chk("nack_err_index", 32'(err_index), 0);
        chk("nack_busy", 32'(busy), 0);
        chk("nack_sb_empty", exp_q.size(), 0);

        // Read-verify mismatches once, then matches; ACK is set to show it is ignored.
        set_rom(ent(2'd1, 8'h30, 8'h5A), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00));
        push_txn(1'b1, 5'd2, 8'h30, 8'h00); push_resp(1'b1, 8'h00);
        push_txn(1'b1, 5'd2, 8'h30, 8'h00); push_resp(1'b1, 8'h5A);
        run_seq(-1, nd, sc);
        chk("rd_txns", n_txn, 2);
        chk("rd_done", nd, 1);
        chk("rd_error_cleared", 32'(error), 0);
        chk("rd_sb_empty", exp_q.size(), 0);

        // Delay of 2 units (2*16 clk) before the write.
        set_rom(ent(2'd2, 8'h00, 8'h02), ent(2'd0, 8'h01, 8'h02), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00));
        push_txn(1'b0, 5'd3, 8'h01, 8'h02); push_resp(1'b0, 8'h00);
        run_seq(-1, nd, sc);
        gap = en_cyc - (sc + 2);
        chk("dly_enable_after_32", 32'(en_cyc >= 0 && gap >= 32), 1);
        chk("dly_txns", n_txn, 1);
        chk("dly_done", nd, 1);

        // No END: table end terminates the run; a mid-run start is ignored.
        set_rom(ent(2'd0, 8'h40, 8'h00), ent(2'd0, 8'h41, 8'h11), ent(2'd0, 8'h42, 8'h22), ent(2'd0, 8'h43, 8'h33));
        for (int i = 0; i < 4; i++) begin
            push_txn(1'b0, 5'd3, 8'h40 + 8'(i), 8'(i * 8'h11)); push_resp(1'b0, 8'h00);
        end
        run_seq(30, nd, sc);
        chk("noend_txns", n_txn, 4);
        chk("noend_done", nd, 1);
        chk("noend_error", 32'(error), 0);
        chk("noend_sb_empty", exp_q.size(), 0);

        // Reset asserted while waiting on the controller.
        set_rom(ent(2'd0, 8'h81, 8'h7E), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00), ent(2'd3, 8'h00, 8'h00));
        push_txn(1'b0, 5'd3, 8'h81, 8'h7E); push_resp(1'b0, 8'h00);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            if (m_active && ifc.i2c_enable) begin hit = 1; break; end
            @(negedge clk);
        end
        chk("reach_wait", 32'(hit), 1);
        chk("pre_rst_addr", 32'(ifc.reg_addr), 32'h81);
        arst_n = 1'b0; #1;
        chk("midrst_ctl", 32'({busy, done, error, err_index, rom_addr}), 0);
        chk("midrst_bus", 32'({ifc.i2c_strobe, ifc.i2c_enable, ifc.reg_rdwr, ifc.reg_addr, ifc.reg_len, ifc.reg_wrdata}), 0);
        @(negedge clk);
        exp_q.delete(); resp_q.delete();
        arst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
